// File: rtl/lorenz_pkg.sv
// -----------------------------------------------------------------------------
// lorenz_pkg
// Shared definitions for the Lorenz Euler datapath and its run controller:
// the controller state encoding, the 7.25 signed fixed-point format and the
// default divergence-guard threshold.
// No ports (package).
// -----------------------------------------------------------------------------
package lorenz_pkg;

    // 7.25 signed fixed point: 7 integer bits (including sign), 25 fraction bits.
    localparam int LZ_INT_BITS   = 7;
    localparam int LZ_FRAC_BITS  = 25;
    localparam int LZ_DATA_WIDTH = LZ_INT_BITS + LZ_FRAC_BITS;

    // 32'h7000_0000 is 56.0 in 7.25 format.
    localparam logic [LZ_DATA_WIDTH-1:0] LZ_GUARD_LIMIT = 32'h7000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } lz_state_e;

endpackage : lorenz_pkg

// File: rtl/lorenz_axis_out_reg.sv
// -----------------------------------------------------------------------------
// lorenz_axis_out_reg
// Single-entry AXI4-Stream output register for one x/y/z sample plus last.
// A capture may coincide with the acceptance of the held beat, so a
// continuously ready sink sees one beat per cycle.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   cap_i           load x_i/y_i/z_i/last_i and mark the entry valid
//   x_i, y_i, z_i   sample to capture
//   last_i          last flag to capture
//   ready_i         downstream accepts the held beat
//   valid_o         entry holds a beat
//   x_o, y_o, z_o   held sample, stable while valid_o & !ready_i
//   last_o          held last flag
//   free_o          a capture is allowed this cycle (empty, or being accepted)
// -----------------------------------------------------------------------------
module lorenz_axis_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_i,
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [DATA_WIDTH-1:0] y_i,
    input  logic [DATA_WIDTH-1:0] z_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] x_o,
    output logic [DATA_WIDTH-1:0] y_o,
    output logic [DATA_WIDTH-1:0] z_o,
    output logic                  last_o,
    output logic                  free_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] x_q, y_q, z_q;
    logic                  last_q;

    // Depends on ready_i, but only feeds the controller; valid_o is a pure flop.
    assign free_o = !valid_q || ready_i;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data registers are reset too, so the bus shows zeros
            // rather than stale or unknown values after reset.
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            last_q  <= 1'b0;
        end else if (cap_i) begin
            valid_q <= 1'b1;
            x_q     <= x_i;
            y_q     <= y_i;
            z_q     <= z_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;
    assign last_o  = last_q;

endmodule : lorenz_axis_out_reg

// File: rtl/lorenz_step_ctrl.sv
// -----------------------------------------------------------------------------
// lorenz_step_ctrl
// Run controller for the Lorenz Euler datapath: loads initial conditions,
// gates integrator steps and emits every decim-th state as an AXIS sample,
// num_samples samples per run. The datapath stalls under backpressure.
//
// Optional feature macro: LORENZ_CTRL_GUARD_EN (divergence guard, adds the
// GUARD_LIMIT parameter; without it err is tied low).
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start                       one-cycle run request, ignored while busy
//   abort                       stop request, honoured in RUN only
//   num_samples, decim          run length / steps per sample, latched at start
//   dp_load                     integrators reload initial conditions
//   dp_step_en                  integrators take one Euler step
//   dp_x, dp_y, dp_z            current integrator state
//   m_axis_*                    AXI4-Stream master (valid/ready/data/last)
//   busy                        high from LOAD through DRAIN
//   done                        one-cycle pulse at run end
//   err                         sticky divergence flag
// -----------------------------------------------------------------------------
module lorenz_step_ctrl
    import lorenz_pkg::*;
#(
    parameter int DATA_WIDTH = LZ_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
`ifdef LORENZ_CTRL_GUARD_EN
    ,
    parameter logic [DATA_WIDTH-1:0] GUARD_LIMIT = DATA_WIDTH'(LZ_GUARD_LIMIT)
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    input  logic [CNT_WIDTH-1:0]  decim,
    output logic                  dp_load,
    output logic                  dp_step_en,
    input  logic [DATA_WIDTH-1:0] dp_x,
    input  logic [DATA_WIDTH-1:0] dp_y,
    input  logic [DATA_WIDTH-1:0] dp_z,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data_x,
    output logic [DATA_WIDTH-1:0] m_axis_data_y,
    output logic [DATA_WIDTH-1:0] m_axis_data_z,
    output logic                  m_axis_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    lz_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] decim_q, decim_d;
    logic [CNT_WIDTH-1:0] ph_q, ph_d;      // steps since the last capture
    logic [CNT_WIDTH-1:0] scnt_q, scnt_d;  // samples captured this run
    logic                 done_q, done_d;

    logic out_free;
    logic cap;
    logic cap_last;
    logic guard_hit;
    logic run_end;
    logic accept_start;

    assign accept_start = (state_q == ST_IDLE) && start;
    assign run_end      = cap && (cap_last || guard_hit);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && (num_samples != '0)) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN:   if (abort || run_end) state_d = ST_DRAIN;
            ST_DRAIN: if (out_free) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Sample 0 is captured before the first step, so sample i holds the state
    // after i*decim steps. The final capture does not step.
    always_comb begin
        dp_load    = 1'b0;
        dp_step_en = 1'b0;
        cap        = 1'b0;
        cap_last   = 1'b0;
        case (state_q)
            ST_LOAD: dp_load = 1'b1;
            ST_RUN: begin
                if (!abort) begin
                    if (ph_q < decim_q) begin
                        dp_step_en = 1'b1;
                    end else if (out_free) begin
                        cap        = 1'b1;
                        cap_last   = ((scnt_q + CNT_ONE) == num_q);
                        dp_step_en = !cap_last && !guard_hit;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- run counters and done pulse ----------------
    always_comb begin
        num_d   = num_q;
        decim_d = decim_q;
        ph_d    = ph_q;
        scnt_d  = scnt_q;
        done_d  = 1'b0;
        if (accept_start) begin
            num_d   = num_samples;
            decim_d = (decim == '0) ? CNT_ONE : decim;
            done_d  = (num_samples == '0);
        end
        // ph starts at decim so the first RUN cycle captures the initial state.
        if (state_q == ST_LOAD) begin
            ph_d   = decim_q;
            scnt_d = '0;
        end
        if (cap) begin
            ph_d   = CNT_ONE;
            scnt_d = scnt_q + CNT_ONE;
        end else if (dp_step_en) begin
            ph_d = ph_q + CNT_ONE;
        end
        // Registered so done lands the cycle after the final acceptance.
        if ((state_q == ST_DRAIN) && out_free) done_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q   <= '0;
            decim_q <= '0;
            ph_q    <= '0;
            scnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            num_q   <= num_d;
            decim_q <= decim_d;
            ph_q    <= ph_d;
            scnt_q  <= scnt_d;
            done_q  <= done_d;
        end
    end

    // ---------------- optional divergence guard ----------------
`ifdef LORENZ_CTRL_GUARD_EN
    logic [DATA_WIDTH-1:0] mag_x, mag_y, mag_z;
    logic                  err_q, err_d;

    // Magnitudes as unsigned; the most negative value maps to 2^(W-1).
    assign mag_x = dp_x[DATA_WIDTH-1] ? -dp_x : dp_x;
    assign mag_y = dp_y[DATA_WIDTH-1] ? -dp_y : dp_y;
    assign mag_z = dp_z[DATA_WIDTH-1] ? -dp_z : dp_z;

    assign guard_hit = (mag_x >= GUARD_LIMIT) || (mag_y >= GUARD_LIMIT) ||
                       (mag_z >= GUARD_LIMIT);

    always_comb begin
        err_d = err_q;
        if (accept_start)          err_d = 1'b0;
        else if (cap && guard_hit) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    assign guard_hit = 1'b0;
    assign err       = 1'b0;
`endif

    // ---------------- output register ----------------
    lorenz_axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .cap_i   (cap),
        .x_i     (dp_x),
        .y_i     (dp_y),
        .z_i     (dp_z),
        .last_i  (cap_last),
        .ready_i (m_axis_ready),
        .valid_o (m_axis_valid),
        .x_o     (m_axis_data_x),
        .y_o     (m_axis_data_y),
        .z_o     (m_axis_data_z),
        .last_o  (m_axis_last),
        .free_o  (out_free)
    );

endmodule : lorenz_step_ctrl

// File: tb/tb_lorenz_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lorenz_step_ctrl
// Scoreboard bench for lorenz_step_ctrl. A counting datapath stub stands in for
// the integrators (x += 1, y += 3, z -= 7 per step), so sample i of a run is
// the initial condition plus i*decim steps of those increments. Stimulus pushes
// the expected beats; a forked monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_lorenz_step_ctrl;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort;
    logic [CW-1:0] num_samples, decim;
    logic          dp_load, dp_step_en;
    logic [DW-1:0] dp_x, dp_y, dp_z;
    logic          m_axis_valid, m_axis_ready, m_axis_last;
    logic [DW-1:0] m_axis_data_x, m_axis_data_y, m_axis_data_z;
    logic          busy, done, err;

    typedef struct {
        logic [DW-1:0] x, y, z;
        logic          last;
        logic          fin;   // final beat of the run: done due next cycle
    } exp_t;

    exp_t exp_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int step_cnt  = 0;
    int load_cnt  = 0;
    int busy_cnt  = 0;
    int valid_cnt = 0;

    logic [DW-1:0] ix = '0, iy = '0, iz = '0;
    logic          guard_jump = 1'b0;

    always #5 clk = ~clk;

    lorenz_step_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .num_samples   (num_samples),
        .decim         (decim),
        .dp_load       (dp_load),
        .dp_step_en    (dp_step_en),
        .dp_x          (dp_x),
        .dp_y          (dp_y),
        .dp_z          (dp_z),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_data_x (m_axis_data_x),
        .m_axis_data_y (m_axis_data_y),
        .m_axis_data_z (m_axis_data_z),
        .m_axis_last   (m_axis_last),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Datapath stub.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_x <= '0;
            dp_y <= '0;
            dp_z <= '0;
        end else if (dp_load) begin
            dp_x <= ix;
            dp_y <= iy;
            dp_z <= iz;
        end else if (dp_step_en) begin
            dp_x <= (guard_jump && (dp_x == ix + 32'd2)) ? 32'h7100_0000 : dp_x + 32'd1;
            dp_y <= dp_y + 32'd3;
            dp_z <= dp_z - 32'd7;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: samples mid-cycle on the falling edge.
    task automatic monitor();
        logic          prev_hold = 1'b0;
        logic [3*DW:0] prev_beat = '0;
        logic          exp_done  = 1'b0;
        exp_t          s;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
                exp_done  = 1'b0;
            end else begin
                check("done_pulse", done, exp_done);
                // An accepted zero-length start pulses done on the next cycle.
                exp_done = !busy && start && (num_samples == '0);
                if (dp_step_en)   step_cnt++;
                if (dp_load)      load_cnt++;
                if (busy)         busy_cnt++;
                if (m_axis_valid) valid_cnt++;
                if (prev_hold) begin
                    check("hold_valid", m_axis_valid, 1'b1);
                    check("hold_beat", {m_axis_data_x, m_axis_data_y, m_axis_data_z, m_axis_last},
                          prev_beat);
                end
                if (m_axis_valid && m_axis_ready) begin
                    check("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        s = exp_q.pop_front();
                        check("beat", {m_axis_data_x, m_axis_data_y, m_axis_data_z, m_axis_last},
                              {s.x, s.y, s.z, s.last});
                        if (s.fin) exp_done = 1'b1;
                    end
                end
                prev_hold = m_axis_valid && !m_axis_ready;
                prev_beat = {m_axis_data_x, m_axis_data_y, m_axis_data_z, m_axis_last};
            end
        end
    endtask

    task automatic push(input int i, input int de, input logic last, input logic fin);
        exp_t e;
        e.x    = ix + 32'(i * de);
        e.y    = iy + 32'(3 * i * de);
        e.z    = iz - 32'(7 * i * de);
        e.last = last;
        e.fin  = fin;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!m_axis_valid && k < budget) begin
            tick(1);
            k++;
        end
        check("valid_reached", m_axis_valid, 1'b1);
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            if (rnd) m_axis_ready = 1'($urandom_range(0, 1));
            tick(1);
            k++;
        end
        check("done_reached", done, 1'b1);
        m_axis_ready = 1'b1;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for 6 cycles after the
    // first valid; 3: ready high plus latency and start-while-busy checks.
    task automatic run(input int n, input int d, input int mode);
        int de, s0, l0, b0, v0, s_stall;
        de = (d == 0) ? 1 : d;
        ix = $urandom_range(0, 32'h00ff_ffff);
        iy = $urandom_range(0, 32'h00ff_ffff);
        iz = $urandom_range(0, 32'h00ff_ffff);
        for (int i = 0; i < n; i++) push(i, de, i == n - 1, i == n - 1);
        s0 = step_cnt;
        l0 = load_cnt;
        b0 = busy_cnt;
        v0 = valid_cnt;
        m_axis_ready = (mode == 2) ? 1'b0 : 1'b1;
        num_samples  = CW'(n);
        decim        = CW'(d);
        start        = 1'b1;
        tick(1);
        start = 1'b0;
        if (mode == 3) begin
            check("load_cycle1", dp_load, 1'b1);
            check("busy_cycle1", busy, 1'b1);
            num_samples = CW'(9);
            decim       = CW'(7);
            start       = 1'b1;
            tick(1);
            start = 1'b0;
            check("load_one_cycle", dp_load, 1'b0);
            check("valid_cycle2", m_axis_valid, 1'b0);
            tick(1);
            check("valid_cycle3", m_axis_valid, 1'b1);
        end
        if (mode == 2) begin
            wait_valid(20);
            s_stall = step_cnt;
            tick(6);
            check("stall_steps", step_cnt - s_stall, 0);
            m_axis_ready = 1'b1;
        end
        wait_done(mode == 1, 400);
        check("step_count", step_cnt - s0, (n == 0) ? 0 : (n - 1) * de);
        check("load_count", load_cnt - l0, (n == 0) ? 0 : 1);
        tick(2);
        if (n == 0) begin
            check("zero_busy", busy_cnt - b0, 0);
            check("zero_valid", valid_cnt - v0, 0);
        end
    endtask

    // Abort after sample 1 is captured while the sink is stalled.
    task automatic run_abort();
        int s0;
        ix = $urandom_range(0, 32'h00ff_ffff);
        iy = $urandom_range(0, 32'h00ff_ffff);
        iz = $urandom_range(0, 32'h00ff_ffff);
        push(0, 1, 1'b0, 1'b0);
        push(1, 1, 1'b0, 1'b1);
        s0 = step_cnt;
        m_axis_ready = 1'b0;
        num_samples  = CW'(6);
        decim        = CW'(1);
        start        = 1'b1;
        tick(1);
        start = 1'b0;
        wait_valid(20);
        m_axis_ready = 1'b1;
        tick(1);
        m_axis_ready = 1'b0;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);
        check("abort_pending", m_axis_valid, 1'b1);
        m_axis_ready = 1'b1;
        wait_done(1'b0, 50);
        check("abort_steps", step_cnt - s0, 2);
        tick(2);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        num_samples  = '0;
        decim        = '0;
        m_axis_ready = 1'b0;
        fork
            monitor();
        join_none
        tick(3);
        check("rst_ctrl", {dp_load, dp_step_en, m_axis_valid, m_axis_last, busy, done, err}, 7'b0);
        check("rst_data", {m_axis_data_x, m_axis_data_y, m_axis_data_z}, 96'b0);
        reset = 1'b0;
        tick(2);

        run(4, 1, 3);
        run(3, 5, 0);
        run(4, 1, 2);
        run_abort();
        run(0, 1, 0);
        run(3, 0, 0);
        for (int r = 0; r < 8; r++) run($urandom_range(1, 6), $urandom_range(0, 4), 1);

`ifdef LORENZ_CTRL_GUARD_EN
        begin
            exp_t e;
            int   s0;
            ix = '0;
            iy = '0;
            iz = '0;
            guard_jump = 1'b1;
            for (int i = 0; i < 3; i++) push(i, 1, 1'b0, 1'b0);
            e.x    = 32'h7100_0000;
            e.y    = 32'd9;
            e.z    = -32'd21;
            e.last = 1'b0;
            e.fin  = 1'b1;
            exp_q.push_back(e);
            s0 = step_cnt;
            m_axis_ready = 1'b1;
            num_samples  = CW'(6);
            decim        = CW'(1);
            start        = 1'b1;
            tick(1);
            start = 1'b0;
            wait_done(1'b0, 100);
            check("guard_err_set", err, 1'b1);
            check("guard_steps", step_cnt - s0, 3);
            guard_jump = 1'b0;
            tick(2);
            run(0, 1, 0);
            check("guard_err_clear", err, 1'b0);
        end
`else
        check("err_tied_low", err, 1'b0);
`endif

        tick(3);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_lorenz_step_ctrl
